ssa_carry_recombine: RTL
========================

# ssa_carry_recombine

Sequential carry-propagation stage for the Schönhage–Strassen multiplier datapath. It sits directly downstream of the 16-point inverse FFT over Z_257. It takes the 16 scaled convolution coefficients as one packed 144-bit word and folds them, one coefficient per cycle, into the final binary product. Each coefficient is weighted by 4^i, for 2-bit digits. The result is returned over a valid/ready handshake, together with overflow and range-error flags.

## Interface
- `N`, 16, number of coefficients (digit positions)
- `CW`, 9, coefficient width; coefficient i occupies `in[CW*i +: CW]`
- `DW`, 2, digit width; coefficient i has weight 2^(DW*i)
- `OW`, N*DW = 32, product width
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `in_valid` input 1: packed coefficient word is valid
- `in_ready` output 1: block can accept a word
- `in` input N*CW = 144: coefficients, c0 in bits [8:0]
- `out_valid` output 1: result is valid
- `out_ready` input 1: consumer accepts the result
- `out` output OW: recombined product, bits [OW-1:0]
- `out_ovf` output 1: final carry was nonzero (result truncated)
- `out_err` output 1: a coefficient exceeded 256 (see Configuration)

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&&in_ready`: latch `in` into a coefficient register, clear carry/idx/result/flags, go to ACCUM.
- ACCUM, each cycle at index idx (0..N-1):
  - t = c[idx] + carry, 10-bit unsigned.
  - result digit idx = t[1:0].
  - carry ← t>>2. Carry register is 8 bits and never saturates.
  - idx increments; after idx=N-1, go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_ovf` = (final carry != 0).
  - `out`, `out_ovf` and `out_err` are held stable until `out_valid&&out_ready`, then the FSM goes to IDLE.
- Values:
  - Coefficients are unsigned and are never reduced mod 257.
  - Inputs 257..511 are processed arithmetically as-is.
- Throughput: one word at a time, no overlap. `in_ready`=0 in ACCUM and DONE.
- Reset values:
  - `in_ready`=0 while `rst_n`=0, and 1 after release.
  - `out_valid`=0, `out`=0, `out_ovf`=0, `out_err`=0.
  - All internal registers are 0.
- Reset mid-operation: all state clears immediately and the partial result is discarded. No output is produced for that word.

## Timing
- Accept edge E0. Edges E1..E16 process c0..c15. `out_valid` rises after E16, so latency from accept to `out_valid` is 16 cycles.
- A handshake at DONE (edge Ek) gives `in_ready`=1 after Ek. The earliest next accept is edge Ek+1. The minimum initiation interval is 18 cycles.
- `out_ready` may be held high in advance; DONE then lasts exactly 1 cycle.
- `in_valid` asserted during ACCUM/DONE is ignored and not captured.
- `out` changes only at the accept edge (cleared) and during ACCUM. It is stable throughout DONE.

## Configuration
- Macro `SSA_RECOMB_RANGE_CHECK_EN`.
- Defined: `out_err` is set in DONE if any latched coefficient > 256. The check is done at the accept edge, and the flag is sticky for that result.
- Undefined: `out_err` is tied to 0. No comparators are built, and arithmetic is identical either way.

## Test plan
- All coefficients 0, `out_ready`=1 → `out_valid` 16 cycles after accept, `out`=0x00000000, `out_ovf`=0.
- c0=256, others 0 → `out`=0x00000100, `out_ovf`=0.
- c[k]=9*min(k+1,15-k) for k=0..14, c15=0 (the convolution of 0xFFFF×0xFFFF) → `out`=0xFFFE0001, `out_ovf`=0.
- c15=4, others 0 → `out`=0x00000000, `out_ovf`=1. Then hold `out_ready`=0 for 5 cycles → `out_valid`, `out` and `out_ovf` stay stable, `in_ready`=0, and an `in_valid` pulse is not captured.
- c3=300, others 0 → `out`=0x00004B00. With the macro `out_err`=1; without it `out_err`=0.
- Assert `rst_n`=0 at cycle 8 of ACCUM → all outputs 0 immediately. After release `in_ready`=1, and a new word c0=1 gives `out`=0x00000001.

Source files
------------

// File: rtl/ssa_carry_recombine.sv
// Folds 16 scaled Z_257 convolution coefficients into a binary product, one coefficient per cycle.
// Optional range flag on coefficients above 256: define SSA_RECOMB_RANGE_CHECK_EN.
module ssa_carry_recombine #(
    parameter int N  = 16,
    parameter int CW = 9,
    parameter int DW = 2,
    parameter int OW = N * DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*CW-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out,
    output logic            out_ovf,
    output logic            out_err
);
    // state  | meaning
    // IDLE   | waiting for a coefficient word
    // ACCUM  | folding coefficient idx into the result
    // DONE   | result presented until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int IW  = $clog2(N);
    localparam int CRW = CW + 1 - DW;

    state_t            state, state_nxt;
    logic [N*CW-1:0]   coef;
    logic [CRW-1:0]    carry;
    logic [IW-1:0]     idx;
    logic [OW-1:0]     result;
    logic [CW:0]       t;
    logic              accept;
    logic              last;

    assign accept = in_valid && in_ready;
    assign last   = (idx == IW'(N - 1));
    // Coefficients are shifted down so the active one always sits in the low CW bits.
    assign t      = {1'b0, coef[CW-1:0]} + (CW + 1)'(carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ACCUM;
            ACCUM:   if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef   <= '0;
            carry  <= '0;
            idx    <= '0;
            result <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                coef   <= in;
                carry  <= '0;
                idx    <= '0;
                result <= '0;
            end
        end else if (state == ACCUM) begin
            result[idx*DW +: DW] <= t[DW-1:0];
            carry                <= t[CW:DW];
            coef                 <= coef >> CW;
            idx                  <= idx + IW'(1);
        end
    end

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign out       = result;
    assign out_ovf   = (state == DONE) && (carry != '0);

`ifdef SSA_RECOMB_RANGE_CHECK_EN
    logic range_hit;
    logic err_q;

    always_comb begin
        range_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in[CW*i +: CW] > CW'(2 ** (CW - 1))) range_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (accept) err_q <= range_hit;
    end

    assign out_err = (state == DONE) && err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule
